kernel_mem_wrack_bridge: RTL and testbench



---
 rtl/kernel_mem_wrack_bridge.sv | 173 +++++++++++++++++
 tb/tb_kernel_mem_wrack_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_mem_wrack_bridge.sv
// Registered Avalon-MM bridge from the kernel global-memory master to one local-memory bank.
// Generates the write acknowledge the memory does not provide: one pulse per completed write burst.
module kernel_mem_wrack_bridge #(
   // Defaults follow the ASP local-memory interface widths.
   parameter int ADDR_WIDTH       = 27,
   parameter int DATA_WIDTH       = 512,
   parameter int BURSTCOUNT_WIDTH = 5,
   parameter int BYTEENABLE_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        reset,

   input  logic                        k_read,
   input  logic                        k_write,
   input  logic [ADDR_WIDTH-1:0]       k_address,
   input  logic [BURSTCOUNT_WIDTH-1:0] k_burstcount,
   input  logic [DATA_WIDTH-1:0]       k_writedata,
   input  logic [BYTEENABLE_WIDTH-1:0] k_byteenable,
   output logic                        k_waitrequest,
   output logic [DATA_WIDTH-1:0]       k_readdata,
   output logic                        k_readdatavalid,
   output logic                        k_writeack,

   output logic                        m_read,
   output logic                        m_write,
   output logic [ADDR_WIDTH-1:0]       m_address,
   output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
   output logic [DATA_WIDTH-1:0]       m_writedata,
   output logic [BYTEENABLE_WIDTH-1:0] m_byteenable,
   input  logic                        m_waitrequest,
   input  logic [DATA_WIDTH-1:0]       m_readdata,
   input  logic                        m_readdatavalid,

   output logic                        err_sticky
);

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_BURST = 2'd1
   } wstate_t;

   localparam logic [BURSTCOUNT_WIDTH-1:0] ONE_BEAT = BURSTCOUNT_WIDTH'(1);

   logic                        cmd_valid_reg;
   logic                        cmd_read_reg;
   logic                        cmd_write_reg;
   logic [ADDR_WIDTH-1:0]       cmd_address_reg;
   logic [BURSTCOUNT_WIDTH-1:0] cmd_burstcount_reg;
   logic [DATA_WIDTH-1:0]       cmd_writedata_reg;
   logic [BYTEENABLE_WIDTH-1:0] cmd_byteenable_reg;

   wstate_t                     wstate_reg;
   logic [BURSTCOUNT_WIDTH-1:0] beats_left_reg;
   logic                        writeack_reg;
   logic                        err_reg;

   logic                        rdv_reg;
   logic [DATA_WIDTH-1:0]       rdata_reg;

   logic                        k_accept;
   logic                        k_both;
   logic                        m_accept;
   logic                        m_accept_write;
   logic                        m_accept_read;
   logic                        bc_zero;
   logic [BURSTCOUNT_WIDTH-1:0] first_beats;

   // The register is free whenever it is empty or draining this cycle.
   assign k_waitrequest  = cmd_valid_reg & m_waitrequest;
   assign k_accept       = (k_read | k_write) & ~k_waitrequest;
   assign k_both         = k_read & k_write;
   assign m_accept       = cmd_valid_reg & ~m_waitrequest;
   assign m_accept_write = m_accept & cmd_write_reg;
   assign m_accept_read  = m_accept & cmd_read_reg;
   assign bc_zero        = (cmd_burstcount_reg == '0);
   assign first_beats    = bc_zero ? ONE_BEAT : cmd_burstcount_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid_reg      <= 1'b0;
         cmd_read_reg       <= 1'b0;
         cmd_write_reg      <= 1'b0;
         cmd_address_reg    <= '0;
         cmd_burstcount_reg <= '0;
         cmd_writedata_reg  <= '0;
         cmd_byteenable_reg <= '0;
      end else if (k_accept) begin
         cmd_valid_reg      <= 1'b1;
         cmd_read_reg       <= k_read & ~k_write;
         cmd_write_reg      <= k_write;
         cmd_address_reg    <= k_address;
         cmd_burstcount_reg <= k_burstcount;
         cmd_writedata_reg  <= k_writedata;
         cmd_byteenable_reg <= k_byteenable;
      end else if (m_accept) begin
         cmd_valid_reg      <= 1'b0;
      end
   end

   // Write-burst tracker: counts downstream write beats and acknowledges the last one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wstate_reg     <= W_IDLE;
         beats_left_reg <= '0;
         writeack_reg   <= 1'b0;
      end else begin
         writeack_reg <= 1'b0;
         case (wstate_reg)
            W_IDLE: begin
               if (m_accept_write) begin
                  if (first_beats == ONE_BEAT) begin
                     writeack_reg <= 1'b1;
                  end else begin
                     beats_left_reg <= first_beats - ONE_BEAT;
                     wstate_reg     <= W_BURST;
                  end
               end
            end
            W_BURST: begin
               if (m_accept_write) begin
                  if (beats_left_reg == ONE_BEAT) begin
                     writeack_reg   <= 1'b1;
                     beats_left_reg <= '0;
                     wstate_reg     <= W_IDLE;
                  end else begin
                     beats_left_reg <= beats_left_reg - ONE_BEAT;
                  end
               end
            end
            default: begin
               wstate_reg     <= W_IDLE;
               beats_left_reg <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if ((k_accept & k_both) |
                   (m_accept_write & (wstate_reg == W_IDLE) & bc_zero) |
                   (m_accept_read & (wstate_reg == W_BURST))) begin
         err_reg <= 1'b1;
      end
   end

   // Read return has no flow control; data holds between valid beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdv_reg   <= 1'b0;
         rdata_reg <= '0;
      end else begin
         rdv_reg <= m_readdatavalid;
         if (m_readdatavalid) begin
            rdata_reg <= m_readdata;
         end
      end
   end

   assign m_read          = cmd_valid_reg & cmd_read_reg;
   assign m_write         = cmd_valid_reg & cmd_write_reg;
   assign m_address       = cmd_address_reg;
   assign m_burstcount    = cmd_burstcount_reg;
   assign m_writedata     = cmd_writedata_reg;
   assign m_byteenable    = cmd_byteenable_reg;

   assign k_writeack      = writeack_reg;
   assign k_readdatavalid = rdv_reg;
   assign k_readdata      = rdata_reg;
   assign err_sticky      = err_reg;

endmodule

// File: tb/tb_kernel_mem_wrack_bridge.sv
// Bench for kernel_mem_wrack_bridge: vector table, hand-written corner sequences and a
// scoreboard that follows every downstream beat, read return and write acknowledge.
module tb_kernel_mem_wrack_bridge;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int BW  = 4;
   localparam int BEW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           k_read, k_write;
   logic [AW-1:0]  k_address;
   logic [BW-1:0]  k_burstcount;
   logic [DW-1:0]  k_writedata;
   logic [BEW-1:0] k_byteenable;
   logic           k_waitrequest;
   logic [DW-1:0]  k_readdata;
   logic           k_readdatavalid;
   logic           k_writeack;
   logic           m_read, m_write;
   logic [AW-1:0]  m_address;
   logic [BW-1:0]  m_burstcount;
   logic [DW-1:0]  m_writedata;
   logic [BEW-1:0] m_byteenable;
   logic           m_waitrequest;
   logic [DW-1:0]  m_readdata;
   logic           m_readdatavalid;
   logic           err_sticky;

   kernel_mem_wrack_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW), .BYTEENABLE_WIDTH(BEW)
   ) dut (
      .clk(clk), .reset(reset),
      .k_read(k_read), .k_write(k_write), .k_address(k_address),
      .k_burstcount(k_burstcount), .k_writedata(k_writedata), .k_byteenable(k_byteenable),
      .k_waitrequest(k_waitrequest), .k_readdata(k_readdata),
      .k_readdatavalid(k_readdatavalid), .k_writeack(k_writeack),
      .m_read(m_read), .m_write(m_write), .m_address(m_address),
      .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ack_cnt  = 0;
   int rdv_cnt  = 0;
   logic drv_last = 1'b1;

   typedef struct {
      logic w; logic r; logic [AW-1:0] a; logic [BW-1:0] bc;
      logic [DW-1:0] d; logic [BEW-1:0] be; logic last;
   } beat_t;
   typedef struct { logic [DW-1:0] d; int c; } rd_t;

   beat_t exp_q[$];
   rd_t   rd_q[$];
   logic  ack_pend  = 1'b0;
   logic  stall_prev = 1'b0;
   logic [63:0] snap = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      beat_t e;
      rd_t   r;
      cyc++;
      if (reset) begin
         exp_q.delete();
         rd_q.delete();
         ack_pend   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (k_writeack === 1'b1 || ack_pend) chk("writeack_timing", 64'(k_writeack), 64'(ack_pend));
         if (k_writeack === 1'b1) ack_cnt++;
         ack_pend = 1'b0;

         if (k_readdatavalid === 1'b1) begin
            rdv_cnt++;
            if (rd_q.size() == 0) begin
               chk("unexpected_readdatavalid", 64'(k_readdatavalid), 64'd0);
            end else begin
               r = rd_q.pop_front();
               chk("readdata_value", 64'(k_readdata), 64'(r.d));
               chk("readdata_latency", 64'(cyc - r.c), 64'd1);
            end
         end
         if (m_readdatavalid) begin
            r.d = m_readdata;
            r.c = cyc;
            rd_q.push_back(r);
         end

         if (stall_prev)
            chk("stall_hold", {6'd0, m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable}, snap);

         if ((m_read | m_write) && !m_waitrequest) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(m_read | m_write), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_write", 64'(m_write), 64'(e.w));
               chk("beat_read", 64'(m_read), 64'(e.r));
               chk("beat_addr", 64'(m_address), 64'(e.a));
               chk("beat_bc", 64'(m_burstcount), 64'(e.bc));
               chk("beat_be", 64'(m_byteenable), 64'(e.be));
               if (e.w) chk("beat_data", 64'(m_writedata), 64'(e.d));
               if (e.w && e.last) ack_pend = 1'b1;
            end
         end
         stall_prev = (m_read | m_write) & m_waitrequest;
         snap = {6'd0, m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable};

         if ((k_read | k_write) && !k_waitrequest) begin
            e.w = k_write; e.r = k_read & ~k_write; e.a = k_address; e.bc = k_burstcount;
            e.d = k_writedata; e.be = k_byteenable; e.last = drv_last;
            exp_q.push_back(e);
         end
      end
   end

   task automatic idle(input int n);
      k_read = 1'b0; k_write = 1'b0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Present one command and hold it until accepted (bounded).
   task automatic issue(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] bc, input logic [DW-1:0] d,
                        input logic [BEW-1:0] be, input logic last, input bit rnd);
      logic acc;
      k_read = r; k_write = w; k_address = a; k_burstcount = bc;
      k_writedata = d; k_byteenable = be; drv_last = last;
      for (int n = 0; n < 200; n++) begin
         if (rnd) m_waitrequest = ($urandom_range(0, 3) == 0);
         #1;
         acc = ~k_waitrequest;
         @(posedge clk); #1;
         if (acc) break;
         if (n == 199) chk("accept_timeout", 64'd0, 64'd1);
      end
      k_read = 1'b0; k_write = 1'b0; drv_last = 1'b1;
   endtask

   typedef struct {
      logic kr; logic kw; logic [AW-1:0] a; logic [BW-1:0] bc; logic [DW-1:0] wd;
      logic mw; logic mrdv; logic [DW-1:0] mrd;
      logic e_mr; logic e_mw; logic [AW-1:0] e_a; logic [DW-1:0] e_wd;
      logic e_ack; logic e_kw; logic e_rdv; logic [DW-1:0] e_rd; logic e_err;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int a0, r0, nw;
      logic [BW-1:0] bc;
      logic [AW-1:0] ad;

      vecs[0]  = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[1]  = '{1'b0,1'b1,16'h0010,4'd1,32'hA1, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[2]  = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b1,16'h0010,32'hA1, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[3]  = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b1,1'b0,1'b0,32'h00,1'b0};
      vecs[4]  = '{1'b1,1'b0,16'h0020,4'd2,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[5]  = '{1'b0,1'b1,16'h0030,4'd1,32'hB2, 1'b1,1'b0,32'h00, 1'b1,1'b0,16'h0020,32'h00, 1'b0,1'b1,1'b0,32'h00,1'b0};
      vecs[6]  = '{1'b0,1'b1,16'h0030,4'd1,32'hB2, 1'b1,1'b0,32'h00, 1'b1,1'b0,16'h0020,32'h00, 1'b0,1'b1,1'b0,32'h00,1'b0};
      vecs[7]  = '{1'b0,1'b1,16'h0030,4'd1,32'hB2, 1'b0,1'b0,32'h00, 1'b1,1'b0,16'h0020,32'h00, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[8]  = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b1,16'h0030,32'hB2, 1'b0,1'b0,1'b0,32'h00,1'b0};
      vecs[9]  = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b1,32'hC3, 1'b0,1'b0,16'h0000,32'h00, 1'b1,1'b0,1'b0,32'h00,1'b0};
      vecs[10] = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'hDD, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b1,32'hC3,1'b0};
      vecs[11] = '{1'b1,1'b1,16'h0040,4'd1,32'hE4, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b0,32'hC3,1'b0};
      vecs[12] = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b1,16'h0040,32'hE4, 1'b0,1'b0,1'b0,32'hC3,1'b1};
      vecs[13] = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b1,1'b0,1'b0,32'hC3,1'b1};
      vecs[14] = '{1'b0,1'b0,16'h0000,4'd0,32'h00, 1'b0,1'b0,32'h00, 1'b0,1'b0,16'h0000,32'h00, 1'b0,1'b0,1'b0,32'hC3,1'b1};

      reset = 1'b1; k_read = 1'b0; k_write = 1'b0; k_address = '0; k_burstcount = '0;
      k_writedata = '0; k_byteenable = '0; m_waitrequest = 1'b1; m_readdata = '0;
      m_readdatavalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_k_waitrequest", 64'(k_waitrequest), 64'd0);
      chk("rst_m_cmd", {62'd0, m_read, m_write}, 64'd0);
      chk("rst_k_ret", {62'd0, k_writeack, k_readdatavalid}, 64'd0);
      chk("rst_err", 64'(err_sticky), 64'd0);
      reset = 1'b0;

      k_byteenable = 4'hF;
      for (int i = 0; i < 15; i++) begin
         k_read = vecs[i].kr; k_write = vecs[i].kw; k_address = vecs[i].a;
         k_burstcount = vecs[i].bc; k_writedata = vecs[i].wd;
         m_waitrequest = vecs[i].mw; m_readdatavalid = vecs[i].mrdv; m_readdata = vecs[i].mrd;
         #1;
         chk($sformatf("v%0d_m_read", i), 64'(m_read), 64'(vecs[i].e_mr));
         chk($sformatf("v%0d_m_write", i), 64'(m_write), 64'(vecs[i].e_mw));
         if (vecs[i].e_mr | vecs[i].e_mw) begin
            chk($sformatf("v%0d_m_address", i), 64'(m_address), 64'(vecs[i].e_a));
            chk($sformatf("v%0d_m_writedata", i), 64'(m_writedata), 64'(vecs[i].e_wd));
         end
         chk($sformatf("v%0d_k_writeack", i), 64'(k_writeack), 64'(vecs[i].e_ack));
         chk($sformatf("v%0d_k_waitrequest", i), 64'(k_waitrequest), 64'(vecs[i].e_kw));
         chk($sformatf("v%0d_k_readdatavalid", i), 64'(k_readdatavalid), 64'(vecs[i].e_rdv));
         chk($sformatf("v%0d_k_readdata", i), 64'(k_readdata), 64'(vecs[i].e_rd));
         chk($sformatf("v%0d_err_sticky", i), 64'(err_sticky), 64'(vecs[i].e_err));
         @(posedge clk); #1;
      end
      idle(2);

      // 4-beat write burst, beat 3 stalled downstream for two cycles.
      a0 = ack_cnt;
      for (int b = 0; b < 3; b++)
         issue(1'b0, 1'b1, 16'h0200, 4'd4, 32'hD000_0000 + 32'(b), 4'hF, 1'b0, 1'b0);
      k_write = 1'b1; k_address = 16'h0200; k_burstcount = 4'd4;
      k_writedata = 32'hD000_0003; drv_last = 1'b1; m_waitrequest = 1'b1;
      repeat (2) begin
         #1;
         chk("stall_k_waitrequest", 64'(k_waitrequest), 64'd1);
         chk("stall_m_writedata", 64'(m_writedata), 64'hD000_0002);
         @(posedge clk); #1;
      end
      m_waitrequest = 1'b0;
      #1;
      chk("stall_release", 64'(k_waitrequest), 64'd0);
      @(posedge clk); #1;
      idle(4);
      chk("burst4_ack_count", 64'(ack_cnt - a0), 64'd1);

      // 8-beat read with gapped return data.
      r0 = rdv_cnt;
      issue(1'b1, 1'b0, 16'h0300, 4'd8, 32'h0, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         m_readdatavalid = 1'b1; m_readdata = $urandom;
         @(posedge clk); #1;
         m_readdatavalid = 1'b0;
         repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      idle(3);
      chk("read8_rdv_count", 64'(rdv_cnt - r0), 64'd8);

      // Reset after 2 of 4 beats.
      issue(1'b0, 1'b1, 16'h0400, 4'd4, 32'hF0, 4'hF, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 16'h0400, 4'd4, 32'hF1, 4'hF, 1'b0, 1'b0);
      idle(1);
      reset = 1'b1;
      #1;
      chk("midrst_m", {m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable}, 64'd0);
      chk("midrst_k", {k_writeack, k_readdatavalid, k_waitrequest, err_sticky, k_readdata}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      a0 = ack_cnt;
      issue(1'b0, 1'b1, 16'h0500, 4'd2, 32'h51, 4'h3, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 16'h0500, 4'd2, 32'h52, 4'hC, 1'b1, 1'b0);
      idle(4);
      chk("postrst_ack_count", 64'(ack_cnt - a0), 64'd1);
      chk("postrst_err", 64'(err_sticky), 64'd0);

      // Zero burstcount counts as one beat and flags an error.
      a0 = ack_cnt;
      issue(1'b0, 1'b1, 16'h0600, 4'd0, 32'h60, 4'hF, 1'b1, 1'b0);
      idle(4);
      chk("bc0_ack_count", 64'(ack_cnt - a0), 64'd1);
      chk("bc0_err", 64'(err_sticky), 64'd1);

      // Random traffic under random backpressure.
      a0 = ack_cnt;
      nw = 0;
      for (int op = 0; op < 64; op++) begin
         bc = 4'($urandom_range(1, 4));
         ad = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            nw++;
            for (int b = 0; b < int'(bc); b++)
               issue(1'b0, 1'b1, ad, bc, $urandom, 4'($urandom), (b == int'(bc) - 1), 1'b1);
         end else begin
            issue(1'b1, 1'b0, ad, bc, $urandom, 4'($urandom), 1'b1, 1'b1);
         end
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(6);
      chk("random_ack_count", 64'(ack_cnt - a0), 64'(nw));
      chk("beats_drained", 64'(exp_q.size()), 64'd0);
      chk("reads_drained", 64'(rd_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
